// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder scan bank: operating modes and the
// legal ranges of the bank's parameters.
package decoder_pkg;

    typedef enum logic [1:0] {
        DIRECT = 2'd0,
        LATCH  = 2'd1,
        SCAN   = 2'd2,
        SWEEP  = 2'd3
    } mode_e;

    localparam int SEL_W_MIN    = 1;
    localparam int SEL_W_MAX    = 4;
    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 8;
    localparam int SCAN_DIV_MIN = 1;
    localparam int SCAN_DIV_MAX = 65535;

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divide-by-DIV counter; tick is high while the count sits at
// DIV-1, and clr restarts the count at 0 on the next edge.
module scan_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || cnt_q == TERM) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == TERM);

endmodule

// File: rtl/decoder_scan_bank.sv
// Bank of active-low decoders sharing one registered address, which is
// loaded directly, latched, scanned, or swept once depending on mode.
module decoder_scan_bank
    import decoder_pkg::*;
#(
    parameter int SEL_W    = 2,
    parameter int CHANNELS = 2,
    parameter int SCAN_DIV = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SEL_W-1:0]               sel,
    input  logic                           le,
    input  logic [1:0]                     mode,
    input  logic                           start,
    input  logic [CHANNELS-1:0]            g_n,
    input  logic [CHANNELS-1:0]            c,
    output logic [CHANNELS*(2**SEL_W)-1:0] y_n,
    output logic [SEL_W-1:0]               addr,
    output logic                           busy,
    output logic                           done
);

    localparam int NOUT = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] ADDR_MAX = '1;

    if (SEL_W < SEL_W_MIN || SEL_W > SEL_W_MAX ||
        CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX ||
        SCAN_DIV < SCAN_DIV_MIN || SCAN_DIV > SCAN_DIV_MAX) begin : g_bad_param
        $error("decoder_scan_bank: parameter out of range");
    end

    mode_e               mode_in;
    mode_e               mode_q, mode_d;
    logic [SEL_W-1:0]    addr_q, addr_d;
    logic [CHANNELS-1:0] en_q, en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                mode_chg;
    logic                step;
    logic                pre_clr;
    logic                tick;

    assign mode_in = mode_e'(mode);

    scan_prescaler #(
        .DIV (SCAN_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .tick (tick)
    );

    // A mode change wipes sweep state and prescaler phase; the new mode's
    // rules then apply from an idle, freshly cleared starting point.
    always_comb begin
        mode_chg = (mode_in != mode_q);
        mode_d   = mode_in;
        en_d     = ~g_n & c;
        addr_d   = addr_q;
        busy_d   = busy_q & ~mode_chg;
        done_d   = 1'b0;
        pre_clr  = mode_chg;
        step     = tick & ~mode_chg;

        unique case (mode_in)
            DIRECT: addr_d = sel;
            LATCH: begin
                if (le) begin
                    addr_d = sel;
                end
            end
            SCAN: begin
                if (step) begin
                    addr_d = addr_q + SEL_W'(1);
                end
            end
            SWEEP: begin
                if (start) begin
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    pre_clr = 1'b1;
                end else if (busy_d && step) begin
                    if (addr_q == ADDR_MAX) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        addr_d = addr_q + SEL_W'(1);
                    end
                end
            end
            default: addr_d = addr_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= DIRECT;
            addr_q <= '0;
            en_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            addr_q <= addr_d;
            en_q   <= en_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Outputs depend on registers only, so reset forces them immediately.
    always_comb begin
        y_n = '1;
        for (int k = 0; k < CHANNELS; k++) begin
            for (int i = 0; i < NOUT; i++) begin
                if (en_q[k] && addr_q == SEL_W'(i)) begin
                    y_n[k*NOUT+i] = 1'b0;
                end
            end
        end
    end

    assign addr = addr_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_decoder_scan_bank.sv
// Scoreboard bench for decoder_scan_bank: directed scenarios plus random
// traffic, compared against a cycle-level behavioural model.
module tb_decoder_scan_bank;

    localparam int SEL_W    = 2;
    localparam int CHANNELS = 2;
    localparam int SCAN_DIV = 4;
    localparam int N        = 2 ** SEL_W;
    localparam int NY       = CHANNELS * N;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [SEL_W-1:0]    sel = '0;
    logic                le = 1'b0;
    logic [1:0]          mode = 2'd0;
    logic                start = 1'b0;
    logic [CHANNELS-1:0] g_n = '1;
    logic [CHANNELS-1:0] c = '0;
    logic [NY-1:0]       y_n;
    logic [SEL_W-1:0]    addr;
    logic                busy;
    logic                done;

    decoder_scan_bank #(
        .SEL_W    (SEL_W),
        .CHANNELS (CHANNELS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sel   (sel),
        .le    (le),
        .mode  (mode),
        .start (start),
        .g_n   (g_n),
        .c     (c),
        .y_n   (y_n),
        .addr  (addr),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NY-1:0]    y_n;
        logic [SEL_W-1:0] addr;
        logic             busy;
        logic             done;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   done_seen = 0;

    // Reference model state: plain integers, prescaler phase as elapsed edges.
    int m_addr, m_mode, m_phase;
    bit m_busy, m_done;
    bit m_en[CHANNELS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_addr = 0; m_mode = 0; m_phase = 0; m_busy = 0; m_done = 0;
        for (int k = 0; k < CHANNELS; k++) m_en[k] = 0;
    endtask

    function automatic logic [NY-1:0] model_y();
        logic [NY-1:0] y;
        y = '1;
        for (int k = 0; k < CHANNELS; k++)
            for (int i = 0; i < N; i++)
                if (m_en[k] && m_addr == i) y[k*N+i] = 1'b0;
        return y;
    endfunction

    task automatic model_step(input int s, input bit l, input int md, input bit st,
                              input logic [CHANNELS-1:0] gn, input logic [CHANNELS-1:0] cc);
        bit chg, tk;
        int next_phase;
        chg = (md != m_mode);
        tk = ((m_phase % SCAN_DIV) == SCAN_DIV - 1) && !chg;
        next_phase = chg ? 0 : m_phase + 1;
        if (chg) m_busy = 0;
        m_done = 0;
        case (md)
            0: m_addr = s;
            1: if (l) m_addr = s;
            2: if (tk) m_addr = (m_addr + 1) % N;
            default: begin
                if (st) begin
                    m_addr = 0; m_busy = 1; next_phase = 0;
                end else if (m_busy && tk) begin
                    if (m_addr == N - 1) begin
                        m_busy = 0; m_done = 1;
                    end else begin
                        m_addr = m_addr + 1;
                    end
                end
            end
        endcase
        for (int k = 0; k < CHANNELS; k++) m_en[k] = !gn[k] && cc[k];
        m_phase = next_phase;
        m_mode = md;
    endtask

    // Called at a falling edge: apply inputs, predict, then wait one cycle.
    task automatic drive(input int s, input bit l, input int md, input bit st,
                         input logic [CHANNELS-1:0] gn, input logic [CHANNELS-1:0] cc);
        exp_t e;
        sel = SEL_W'(s); le = l; mode = 2'(md); start = st; g_n = gn; c = cc;
        model_step(s, l, md, st, gn, cc);
        e.y_n = model_y();
        e.addr = SEL_W'(m_addr);
        e.busy = m_busy;
        e.done = m_done;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_y_n"}, 32'(y_n), 32'(NY'('1)));
        chk({tag, "_addr"}, 32'(addr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("y_n", 32'(y_n), 32'(e.y_n));
                chk("addr", 32'(addr), 32'(e.addr));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("done", 32'(done), 32'(e.done));
                if (done) done_seen++;
            end
        end
    end

    initial begin : stim
        int md, guard;
        model_reset();
        #2;
        chk_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Direct decode, then a latched address that ignores later sel.
        repeat (3) drive(2, 0, 0, 0, 2'b00, 2'b11);
        chk("direct_y_n_value", 32'(y_n), 32'h0000_00BB);
        drive(1, 1, 1, 0, 2'b00, 2'b11);
        repeat (3) drive(3, 0, 1, 0, 2'b00, 2'b11);
        chk("latch_y_n_value", 32'(y_n), 32'h0000_00DD);

        // Channel gating by g_n and by c.
        drive(2, 0, 0, 0, 2'b10, 2'b11);
        drive(1, 0, 0, 0, 2'b00, 2'b01);
        drive(3, 0, 0, 0, 2'b01, 2'b11);

        // Scan with only channel 0 enabled.
        repeat (20) drive($urandom_range(0, N - 1), 1, 2, 1, 2'b10, 2'b11);

        // Full sweep, idle hold, then a restart part way through.
        drive(0, 0, 3, 0, 2'b00, 2'b11);
        drive(0, 0, 3, 1, 2'b00, 2'b11);
        repeat (22) drive($urandom_range(0, N - 1), 1, 3, 0, 2'b00, 2'b11);
        drive(0, 0, 3, 1, 2'b00, 2'b11);
        repeat (9) drive(0, 0, 3, 0, 2'b00, 2'b11);
        drive(0, 0, 3, 1, 2'b00, 2'b11);
        repeat (20) drive(0, 0, 3, 0, 2'b00, 2'b11);
        chk("sweep_done_count", 32'(done_seen), 32'd2);

        // Asynchronous reset in the middle of a sweep.
        drive(0, 0, 3, 1, 2'b00, 2'b11);
        guard = 0;
        while (m_addr != 2 && guard < 20) begin
            drive(0, 0, 3, 0, 2'b00, 2'b11);
            guard++;
        end
        chk("midsweep_busy_before", 32'(busy), 32'd1);
        chk("midsweep_addr_before", 32'(addr), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("midsweep_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Random traffic with occasional mode changes and sweep starts.
        md = 0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 29) == 0) md = $urandom_range(0, 3);
            drive($urandom_range(0, N - 1), $urandom_range(0, 3) == 0, md,
                  $urandom_range(0, 39) == 0,
                  CHANNELS'($urandom), CHANNELS'($urandom | $urandom));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder_scan_bank.md
DECODER_SCAN_BANK -- requirements
Module: decoder_scan_bank

Interface
REQ-001 SHALL have parameter SEL_W, default 2, meaning select width; each channel has 2**SEL_W outputs; legal range 1..4.
REQ-002 SHALL have parameter CHANNELS, default 2, meaning number of independent decoder channels sharing one select; legal range 1..8.
REQ-003 SHALL have parameter SCAN_DIV, default 4, meaning clock cycles per scan step; legal range 1..65535.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1, meaning the only clock, rising edge.
REQ-006 SHALL have port rst, input, 1, meaning the asynchronous, active-high reset.
REQ-007 SHALL have port sel, input, SEL_W, meaning the external select address.
REQ-008 SHALL have port le, input, 1, meaning the address latch load strobe in LATCH mode.
REQ-009 SHALL have port mode, input, 2, meaning 0 DIRECT, 1 LATCH, 2 SCAN, 3 SWEEP.
REQ-010 SHALL have port start, input, 1, meaning a one-cycle sweep trigger in SWEEP mode.
REQ-011 SHALL have port g_n, input, CHANNELS, meaning per-channel active-low enable.
REQ-012 SHALL have port c, input, CHANNELS, meaning per-channel active-high data/enable, ANDed with ~g_n.
REQ-013 SHALL have port y_n, output, CHANNELS*2**SEL_W, meaning active-low decoded outputs; bit k*2**SEL_W+i is channel k, address i.
REQ-014 SHALL have port addr, output, SEL_W, meaning the current registered address.
REQ-015 SHALL have port busy, output, 1, meaning a sweep is in progress.
REQ-016 SHALL have port done, output, 1, meaning a one-cycle pulse at sweep completion.

Function
REQ-017 SHALL register en_q[k] = ~g_n[k] & c[k] every cycle.
REQ-018 SHALL drive y_n[k*2**SEL_W+i] low iff en_q[k] is 1 and addr_q equals i, decoded from registers only, with no input-to-output combinational path.
REQ-019 In DIRECT mode, SHALL load addr_q from sel every cycle, giving 1-cycle latency from sel to y_n.
REQ-020 In LATCH mode, SHALL load addr_q from sel only in cycles with le=1, and hold it otherwise.
REQ-021 In SCAN mode, SHALL increment addr_q once per tick and wrap from 2**SEL_W-1 to 0.
REQ-022 The prescaler SHALL count 0..SCAN_DIV-1 and raise tick at terminal count; SCAN_DIV=1 SHALL give a tick every cycle.
REQ-023 In SWEEP mode while idle, start=1 SHALL set addr_q to 0, set busy to 1 and clear the prescaler.
REQ-024 While busy, each tick SHALL advance addr_q; a tick at addr_q = 2**SEL_W-1 SHALL clear busy, pulse done for one cycle and hold addr_q at max.
REQ-025 start while busy SHALL restart the sweep from 0, with no done pulse.
REQ-026 Any mode change SHALL clear the prescaler, clear busy and suppress done in the same cycle; addr_q SHALL then follow the rules of the new mode.
REQ-027 In SWEEP mode while idle, addr_q SHALL hold; le SHALL be ignored outside LATCH mode, and start SHALL be ignored outside SWEEP mode.

Reset
REQ-028 rst SHALL immediately clear addr_q, en_q, the prescaler, busy and done, forcing all y_n to 1.
REQ-029 rst asserted mid-sweep SHALL abort the sweep without a done pulse; the first clock edge after deassertion SHALL apply normal rules.

Structure
REQ-030 A shared package decoder_pkg SHALL hold the mode enum (DIRECT, LATCH, SCAN, SWEEP) and the parameter limit constants.
REQ-031 The prescaler SHALL be a sub-module scan_prescaler (parameter DIV, with clk, rst, clr and tick ports).

Verification
REQ-032 DIRECT mode, defaults, g_n=2'b00, c=2'b11, sel=2 -> the next cycle y_n=8'b1011_1011.
REQ-033 LATCH mode, sel=1 with le=1, then sel=3 with le=0 -> addr stays 1 and y_n=8'b1101_1101.
REQ-034 SCAN mode, SCAN_DIV=4, channel 0 only enabled -> addr steps 0,1,2,3,0 every 4 cycles, with the y_n low bit rotating.
REQ-035 SWEEP mode, start pulse -> busy for 16 cycles, done one cycle as addr reaches 3, then hold; a second start at step 2 restarts from 0 with no done.
REQ-036 rst asserted mid-sweep at addr=2 -> y_n=all ones, busy=0, done=0 with no clock edge required.
REQ-037 Channel gating: g_n[1]=1 or c[1]=0 -> channel 1 outputs all ones, while channel 0 decodes unaffected.
